// File: rtl/coeff_update_sequencer_if.sv
// coeff_update_sequencer_if: coefficient push, commit command and coefficient write bus
interface coeff_update_sequencer_if;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_axis;
  logic [1:0]  cmd_bank;
  logic        cmd_swap;
  logic        cmd_ready;
  logic        update_en;
  logic [1:0]  update_axis;
  logic [1:0]  update_bank;
  logic [3:0]  update_index;
  logic [15:0] update_value;
  modport master (
    output wr_valid, wr_data, cmd_valid, cmd_axis, cmd_bank, cmd_swap,
    input  wr_ready, cmd_ready, update_en, update_axis, update_bank, update_index, update_value
  );
  modport slave (
    input  wr_valid, wr_data, cmd_valid, cmd_axis, cmd_bank, cmd_swap,
    output wr_ready, cmd_ready, update_en, update_axis, update_bank, update_index, update_value
  );
endinterface

// File: rtl/coeff_update_sequencer.sv
// coeff_update_sequencer: buffers a tap set, streams it to the signal path and optionally swaps the active bank on a sample boundary
module coeff_update_sequencer #(
  parameter int NTAPS = 16
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  coeff_update_sequencer_if.slave     bus,
  input  logic                        sample_strobe,
  output logic [1:0]                  x_bank,
  output logic [1:0]                  y_bank,
  output logic [1:0]                  z_bank,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  input  logic                        err_clr
);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_SAMPLE, FINISH} state_t;
  localparam logic [4:0] FULL = 5'(NTAPS);
  localparam logic [3:0] LAST = 4'(NTAPS - 1);
  state_t      state, state_nxt;
  logic [15:0] tap_buf [NTAPS];
  logic [4:0]  count;
  logic [3:0]  next_index;
  logic [1:0]  cur_bank;
  logic        lat_swap, idle, accept, reject, last_tap, wr_fire, swap_now;
  always_comb begin
    idle       = state == IDLE;
    cur_bank   = bus.cmd_axis == 2'd0 ? x_bank : bus.cmd_axis == 2'd1 ? y_bank : z_bank;
    reject     = idle && bus.cmd_valid && (count != FULL || bus.cmd_axis == 2'd3 || bus.cmd_bank == cur_bank);
    accept     = idle && bus.cmd_valid && !reject;
    last_tap   = bus.update_index == LAST;
    next_index = bus.update_index + 4'd1;
    wr_fire    = bus.wr_valid && bus.wr_ready;
    swap_now   = state == WAIT_SAMPLE && sample_strobe;
  end
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  always_comb begin
    state_nxt = idle ? (accept ? STREAM : IDLE) :
                state == STREAM ? (last_tap ? (lat_swap ? WAIT_SAMPLE : FINISH) : STREAM) :
                state == WAIT_SAMPLE ? (sample_strobe ? FINISH : WAIT_SAMPLE) : IDLE;
  end
  always_comb begin
    bus.cmd_ready = idle;
    bus.wr_ready  = idle && count < FULL && !bus.cmd_valid;
    busy          = !idle;
    done          = state == FINISH;
  end
  always_ff @(posedge sys_clk)
    if (wr_fire) tap_buf[count[3:0]] <= bus.wr_data;
  // The latched axis/bank live in the update bus registers, which hold while idle.
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      count            <= '0;
      error            <= 1'b0;
      lat_swap         <= 1'b0;
      x_bank           <= '0;
      y_bank           <= '0;
      z_bank           <= '0;
      bus.update_en    <= 1'b0;
      bus.update_axis  <= '0;
      bus.update_bank  <= '0;
      bus.update_index <= '0;
      bus.update_value <= '0;
    end else begin
      count <= (reject || state == FINISH) ? '0 : wr_fire ? count + 5'd1 : count;
      error <= reject || (error && !err_clr);
      if (accept) begin
        lat_swap         <= bus.cmd_swap;
        bus.update_en    <= 1'b1;
        bus.update_axis  <= bus.cmd_axis;
        bus.update_bank  <= bus.cmd_bank;
        bus.update_index <= '0;
        bus.update_value <= tap_buf[0];
      end else if (state == STREAM) begin
        bus.update_en <= !last_tap;
        if (!last_tap) begin
          bus.update_index <= next_index;
          bus.update_value <= tap_buf[next_index];
        end
      end
      if (swap_now && bus.update_axis == 2'd0) x_bank <= bus.update_bank;
      if (swap_now && bus.update_axis == 2'd1) y_bank <= bus.update_bank;
      if (swap_now && bus.update_axis == 2'd2) z_bank <= bus.update_bank;
    end
endmodule
